// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add multiplier for sign-magnitude operands.
// One operand pair is taken per accepted start, and the result appears after
// a fixed MAG_W+1 cycle latency together with a one-cycle done pulse.
module mul_seq #(
  parameter int MAG_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAG_W:0]     multiplicand,
  input  logic [MAG_W:0]     multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*MAG_W:0]   product,
  output logic               zero
);

  localparam int CNT_W = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  logic [2*MAG_W-1:0]   acc;
  logic [2*MAG_W-1:0]   mcand;
  logic [MAG_W-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 sign;
  logic [2*MAG_W-1:0]   acc_next;

  // Accumulator value after the current RUN step; the final step's value is
  // written straight into product so it is visible during the DONE cycle.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      zero    <= 1'b1;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{MAG_W{1'b0}}, multiplicand[MAG_W-1:0]};
            mplier <= multiplier[MAG_W-1:0];
            sign   <= multiplicand[MAG_W] ^ multiplier[MAG_W];
            acc    <= '0;
            cnt    <= CNT_W'(MAG_W);
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            product <= {sign & (acc_next != '0), acc_next};
            zero    <= (acc_next == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized and directed checks of mul_seq against a plain
// arithmetic sign-magnitude multiply model.
module tb_mul_seq;

  localparam int W   = 2;
  localparam int OPW = W + 1;
  localparam int PW  = 2 * W + 1;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [OPW-1:0] multiplicand;
  logic [OPW-1:0] multiplier;
  logic           busy;
  logic           done;
  logic [PW-1:0]  product;
  logic           zero;

  int errors = 0;
  int checks = 0;

  mul_seq #(.MAG_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .zero         (zero)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sign-magnitude product from integer arithmetic; zero magnitude is unsigned.
  function automatic logic [PW-1:0] ref_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    int unsigned   m;
    logic [PW-2:0] mag;
    logic          s;
    m   = int'(a[W-1:0]) * int'(b[W-1:0]);
    mag = (PW-1)'(m);
    s   = (a[W] ^ b[W]) && (m != 0);
    return {s, mag};
  endfunction

  // Present one operand pair for a single accepting edge, then drop start.
  task automatic applyStimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = OPW'($urandom);
    multiplier   = OPW'($urandom);
  endtask

  // Step edges until done is seen, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int edges, output bit timedout);
    edges    = 0;
    timedout = 1'b0;
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    if (done !== 1'b1) timedout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (product !== '0) begin errors++; $display("[TB] FAIL reset_product: got %b expected 0", product); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero: got %b expected 1", zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [OPW-1:0] ta [5] = '{3'b011, 3'b111, 3'b111, 3'b100, 3'b000};
    logic [OPW-1:0] tb [5] = '{3'b010, 3'b011, 3'b111, 3'b111, 3'b010};
    logic [PW-1:0]  te [5] = '{5'b00110, 5'b11001, 5'b01001, 5'b00000, 5'b00000};
    logic [PW-1:0]  exp_p;
    int edges;
    bit to;
    for (int i = 0; i < 5; i++) begin
      exp_p = te[i];
      applyStimulus(ta[i], tb[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL dir_busy[%0d]: got %b expected 1", i, busy); end
      wait_done(edges, to);
      checks++; if (to || edges != W) begin errors++; $display("[TB] FAIL dir_latency[%0d]: got %0d edges after accept expected %0d", i, edges, W); end
      checks++; if (product !== exp_p) begin errors++; $display("[TB] FAIL dir_product[%0d]: got %b expected %b", i, product, exp_p); end
      checks++; if (zero !== (exp_p[PW-2:0] == '0)) begin errors++; $display("[TB] FAIL dir_zero[%0d]: got %b expected %b", i, zero, (exp_p[PW-2:0] == '0)); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dir_done_width[%0d]: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned    off;
    int unsigned    idx;
    logic [PW-1:0]  exp_p;
    logic [5:0]     pair;
    int edges;
    bit to;
    off   = $urandom_range(63);
    pair  = 6'(off);
    start = 1'b1;
    multiplicand = pair[5:3];
    multiplier   = pair[2:0];
    exp_p = ref_mul(pair[5:3], pair[2:0]);
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      wait_done(edges, to);
      checks++; if (to || edges != W) begin errors++; $display("[TB] FAIL b2b_latency[%0d]: got %0d edges expected %0d", i, edges, W); end
      checks++; if (product !== exp_p) begin errors++; $display("[TB] FAIL b2b_product[%0d]: got %b expected %b", i, product, exp_p); end
      checks++; if (zero !== (exp_p[PW-2:0] == '0)) begin errors++; $display("[TB] FAIL b2b_zero[%0d]: got %b expected %b", i, zero, (exp_p[PW-2:0] == '0)); end
      if (i < 63) begin
        idx  = (off + i + 1) % 64;
        pair = 6'(idx);
        multiplicand = pair[5:3];
        multiplier   = pair[2:0];
        exp_p = ref_mul(pair[5:3], pair[2:0]);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_final_busy: got %b expected 0", busy); end
  endtask

  task automatic test_start_ignored();
    int edges;
    bit to;
    applyStimulus(3'b011, 3'b011);
    start        = 1'b1;
    multiplicand = 3'b001;
    multiplier   = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(edges, to);
    checks++; if (to || edges != W - 1) begin errors++; $display("[TB] FAIL ign_latency: got %0d edges expected %0d", edges, W - 1); end
    checks++; if (product !== 5'b01001) begin errors++; $display("[TB] FAIL ign_product: got %b expected 01001", product); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_queued[%0d]: got done=%b busy=%b expected 0 0", k, done, busy); end
    end
  endtask

  task automatic test_reset_abort();
    int edges;
    bit to;
    bit saw_done;
    applyStimulus(3'b011, 3'b011);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (product !== '0) begin errors++; $display("[TB] FAIL abort_product: got %b expected 0", product); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL abort_zero: got %b expected 1", zero); end
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("[TB] FAIL abort_no_done: got done pulse expected none"); end
    applyStimulus(3'b010, 3'b010);
    wait_done(edges, to);
    checks++; if (to || edges != W) begin errors++; $display("[TB] FAIL abort_latency: got %0d edges expected %0d", edges, W); end
    checks++; if (product !== 5'b00100) begin errors++; $display("[TB] FAIL abort_product_after: got %b expected 00100", product); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [PW-1:0]  exp_p;
    int gap;
    for (int i = 0; i < 40; i++) begin
      a = OPW'($urandom);
      b = OPW'($urandom);
      exp_p = ref_mul(a, b);
      applyStimulus(a, b);
      for (int k = 0; k < W; k++) begin
        start        = 1'($urandom);
        multiplicand = OPW'($urandom);
        multiplier   = OPW'($urandom);
        @(posedge clk); #1;
      end
      start = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rnd_done[%0d]: got %b expected 1", i, done); end
      checks++; if (product !== exp_p) begin errors++; $display("[TB] FAIL rnd_product[%0d]: a=%b b=%b got %b expected %b", i, a, b, product, exp_p); end
      checks++; if (zero !== (exp_p[PW-2:0] == '0)) begin errors++; $display("[TB] FAIL rnd_zero[%0d]: got %b expected %b", i, zero, (exp_p[PW-2:0] == '0)); end
      gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting mul_seq bench");
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
